// File: rtl/dsp_fetch_queue.sv
// Instruction fetch stage: PC-driven memory reads feeding a DEPTH-entry prefetch queue toward decode.
// Define DSP_FETCH_PERF_EN to add the stall_count port (cycles with no valid instruction).
module dsp_fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  read_addr,
  input  logic [INSTR_W-1:0] read_data,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
`ifdef DSP_FETCH_PERF_EN
  ,
  output logic [31:0]        stall_count
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] word_q [DEPTH];
  logic [ADDR_W-1:0]  wpc_q [DEPTH];

  logic             pop, push, issue, room;
  logic [CNT_W-1:0] occ;

  assign instr_valid     = (count_q != '0);
  assign read_addr       = pc_q;
  assign instruction_out = instr_valid ? word_q[rd_ptr_q] : '0;
  assign instr_pc        = instr_valid ? wpc_q[rd_ptr_q] : '0;

  always_comb begin
    pop   = instr_valid & instr_ready;
    push  = inflight_q & ~jump_flag;
    // a slot is reserved for the word in flight, so issue only when it is guaranteed a home
    occ   = count_q + CNT_W'(inflight_q);
    room  = occ < CNT_W'(DEPTH);
    issue = ~jump_flag & (room | pop);

    pc_d       = pc_q;
    ipc_d      = ipc_q;
    inflight_d = issue;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (jump_flag) begin
      pc_d     = jump_addr;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        ipc_d = pc_q;
        pc_d  = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // queue storage needs no reset; count gates what is visible
  always_ff @(posedge clk) begin
    if (rst && push) begin
      word_q[wr_ptr_q] <= read_data;
      wpc_q[wr_ptr_q]  <= ipc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(push && count_q == CNT_W'(DEPTH)))
      else $error("dsp_fetch_queue: push into full queue");
  end

`ifdef DSP_FETCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!instr_valid && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_dsp_fetch_queue.sv
// Randomized bench for dsp_fetch_queue against a queue-based model of the fetch rules.
module tb_dsp_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic [15:0] read_addr, jump_addr, instr_pc;
  logic [31:0] read_data, instruction_out;
  logic        jump_flag, instr_valid, instr_ready;
  logic [7:0]  read_addr8, ja8, pc8;
  logic [31:0] read_data8, out8;
  logic        jf8, v8, rdy8;
`ifdef DSP_FETCH_PERF_EN
  logic [31:0] stall_count, stall8;
`endif

  dsp_fetch_queue #(.ADDR_W(16), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(16'h0010)) u_dut (
    .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(read_data),
    .jump_flag(jump_flag), .jump_addr(jump_addr), .instruction_out(instruction_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef DSP_FETCH_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  dsp_fetch_queue #(.ADDR_W(8), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut8 (
    .clk(clk), .rst(rst), .read_addr(read_addr8), .read_data(read_data8),
    .jump_flag(jf8), .jump_addr(ja8), .instruction_out(out8),
    .instr_pc(pc8), .instr_valid(v8), .instr_ready(rdy8)
`ifdef DSP_FETCH_PERF_EN
    , .stall_count(stall8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] key;
  always @(posedge clk) begin
    read_data  <= 32'(read_addr) ^ key;
    read_data8 <= 32'(read_addr8);
  end

  // reference model
  logic [15:0] m_pc, m_ipc;
  bit          m_infl;
  logic [31:0] m_stall;
  logic [15:0] m_qpc[$];
  logic [31:0] m_qw[$];
  logic [15:0] acc[$];
  logic [31:0] accw[$];
  logic [7:0]  acc8[$];
  logic [31:0] acc8w[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [64:0] obs;
  assign obs = {read_addr, instr_valid, instr_pc, instruction_out};

  function automatic logic [64:0] exp_obs();
    if (m_qpc.size() == 0) return {m_pc, 1'b0, 16'h0, 32'h0};
    return {m_pc, 1'b1, m_qpc[0], m_qw[0]};
  endfunction

  task automatic model_step(input logic r, input logic j, input logic [15:0] a, input logic rd);
    bit v, p, iss;
    if (!r) begin
      m_pc = 16'h0010; m_infl = 0; m_stall = 0; m_qpc.delete(); m_qw.delete();
    end else begin
      v = (m_qpc.size() != 0);
      p = v && rd;
      if (!v && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (j) begin
        m_qpc.delete(); m_qw.delete(); m_infl = 0; m_pc = a;
      end else begin
        iss = ((m_qpc.size() + int'(m_infl)) < DEPTH) || p;
        if (p) begin void'(m_qpc.pop_front()); void'(m_qw.pop_front()); end
        if (m_infl) begin m_qpc.push_back(m_ipc); m_qw.push_back(32'(m_ipc) ^ key); end
        if (iss) begin m_ipc = m_pc; m_pc = m_pc + 16'd1; end
        m_infl = iss;
      end
    end
  endtask

  task automatic tick(input logic r, input logic j, input logic [15:0] a, input logic rd);
    rst = r; jump_flag = j; jump_addr = a; instr_ready = rd;
    #1;
    if (r && instr_valid && rd) begin acc.push_back(instr_pc); accw.push_back(instruction_out); end
    if (r && v8 && rdy8) begin acc8.push_back(pc8); acc8w.push_back(out8); end
    @(posedge clk);
    model_step(r, j, a, rd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    key = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (obs !== {16'h0010, 1'b0, 16'h0, 32'h0}) begin
        n_bad++; $display("FAIL reset_hold%0d: got %h want %h", i, obs, {16'h0010, 1'b0, 16'h0, 32'h0});
      end
    end
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    n_cmp++;
    if ({read_addr, instr_valid} !== {16'h0011, 1'b0}) begin
      n_bad++; $display("FAIL reset_e0: got addr %h valid %b want 0011 0", read_addr, instr_valid);
    end
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    n_cmp++;
    if ({instr_valid, instr_pc, instruction_out} !== {1'b1, 16'h0010, 32'h0000_0010}) begin
      n_bad++; $display("FAIL reset_first: got v%b pc %h d %h want v1 0010 00000010", instr_valid, instr_pc, instruction_out);
    end
  endtask

  task automatic test_stream();
    key = $urandom;
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    acc.delete(); accw.delete();
    for (int i = 0; i < 22; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL stream_cyc%0d: got %h want %h", i, obs, exp_obs()); end
    end
    n_cmp++;
    if (acc.size() < 20) begin n_bad++; $display("FAIL stream_count: got %0d want >=20", acc.size()); end
    else for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if ({acc[i], accw[i]} !== {16'h0010 + 16'(i), (32'h10 + 32'(i)) ^ key}) begin
        n_bad++; $display("FAIL stream_seq%0d: got %h/%h want %h", i, acc[i], accw[i], 16'h0010 + 16'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    key = $urandom;
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i, obs, exp_obs()); end
    end
    n_cmp++;
    if ({read_addr, instr_valid, instr_pc} !== {16'h0014, 1'b1, 16'h0010}) begin
      n_bad++; $display("FAIL bp_full: got addr %h v%b pc %h want 0014 1 0010", read_addr, instr_valid, instr_pc);
    end
    acc.delete(); accw.delete();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL bp_drain%0d: got %h want %h", i, obs, exp_obs()); end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= acc.size() || acc[i] !== 16'h0010 + 16'(i)) begin
        n_bad++; $display("FAIL bp_order%0d: got %h want %h", i, (i < acc.size()) ? acc[i] : 16'hxxxx, 16'h0010 + 16'(i));
      end
    end
  endtask

  task automatic test_jump();
    key = $urandom;
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 16'h0, 1'b0);
    acc.delete(); accw.delete();
    tick(1'b1, 1'b1, 16'h0100, 1'b1);
    n_cmp++;
    if (acc.size() != 1 || acc[0] !== 16'h0010) begin
      n_bad++; $display("FAIL jump_pop: got %0d pops first %h want 1 pop 0010", acc.size(), (acc.size() > 0) ? acc[0] : 16'hxxxx);
    end
    n_cmp++;
    if ({read_addr, instr_valid} !== {16'h0100, 1'b0}) begin
      n_bad++; $display("FAIL jump_flush: got addr %h v%b want 0100 0", read_addr, instr_valid);
    end
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL jump_gap2: got v%b want 0", instr_valid); end
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0100}) begin
      n_bad++; $display("FAIL jump_target: got v%b pc %h want 1 0100", instr_valid, instr_pc);
    end
    acc.delete(); accw.delete();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL jump_after%0d: got %h want %h", i, obs, exp_obs()); end
    end
    for (int i = 0; i < acc.size(); i++) begin
      n_cmp++;
      if (acc[i] !== 16'h0100 + 16'(i)) begin n_bad++; $display("FAIL jump_seq%0d: got %h want %h", i, acc[i], 16'h0100 + 16'(i)); end
    end
  endtask

  task automatic test_random();
    logic r, j, rd;
    logic [15:0] a;
    key = $urandom;
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) != 0);
      j  = ($urandom_range(9) == 0);
      a  = 16'($urandom);
      rd = ($urandom_range(2) != 0);
      tick(r, j, a, rd);
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp_obs()); end
`ifdef DSP_FETCH_PERF_EN
      n_cmp++;
      if (stall_count !== m_stall) begin n_bad++; $display("FAIL random_stall%0d: got %0d want %0d", i, stall_count, m_stall); end
`endif
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
    jf8 = 1'b1; ja8 = 8'hFE; rdy8 = 1'b1;
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    jf8 = 1'b0;
    n_cmp++;
    if (read_addr8 !== 8'hFE) begin n_bad++; $display("FAIL wrap_addr: got %h want fe", read_addr8); end
    acc8.delete(); acc8w.delete();
    for (int i = 0; i < 12 && acc8.size() < 4; i++) tick(1'b1, 1'b0, 16'h0, 1'b0);
    n_cmp++;
    if (acc8.size() < 4) begin n_bad++; $display("FAIL wrap_timeout: got %0d words want 4", acc8.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({acc8[i], acc8w[i]} !== {exp_seq[i], 24'h0, exp_seq[i]}) begin
        n_bad++; $display("FAIL wrap_seq%0d: got %h/%h want %h", i, acc8[i], acc8w[i], exp_seq[i]);
      end
    end
  endtask

`ifdef DSP_FETCH_PERF_EN
  task automatic test_perf();
    key = $urandom;
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 16'h0, 1'b1);
    tick(1'b1, 1'b1, 16'h0200, 1'b1);
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if (stall_count !== 32'd4) begin n_bad++; $display("FAIL perf_count: got %0d want 4", stall_count); end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if (stall_count !== 32'd4) begin n_bad++; $display("FAIL perf_hold: got %0d want 4", stall_count); end
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if (stall_count !== 32'd0) begin n_bad++; $display("FAIL perf_reset: got %0d want 0", stall_count); end
  endtask
`endif

  initial begin
    rst = 1'b0; jump_flag = 1'b0; jump_addr = '0; instr_ready = 1'b0;
    jf8 = 1'b0; ja8 = '0; rdy8 = 1'b1; key = '0;
    m_pc = 16'h0010; m_ipc = '0; m_infl = 0; m_stall = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_random();
    test_wrap();
`ifdef DSP_FETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
